multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, ALU control code width (minimum 3).
REQ-002 Parameter REG_ADDR_W, default 4, register-address width of rd.
REQ-003 Parameter PC_REG, default 15, register index that aliases the PC.
REQ-004 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 op  in  2  instruction class: 0 data-processing, 1 memory, 2 branch, 3 undefined.
REQ-008 funct  in  6  funct[5] immediate select, funct[4:1] cmd, funct[0] S bit (DP) or L bit (memory).
REQ-009 rd  in  REG_ADDR_W  destination register.
REQ-010 cond_ex  in  1  condition-check result for the current instruction, sampled live.
REQ-011 mem_ready  in  1  memory handshake; access completes in a cycle where it is high.
REQ-012 Outputs, all 1 bit unless stated: ir_write, pc_write, reg_w, mem_w, adr_src, alu_src_a, no_write, shift_flag, illegal; result_src, alu_src_b, imm_src, reg_src, flag_w are 2 bits; alu_control is ALU_CTRL_W bits; retired is CNT_W bits; state is 4 bits (debug).

Function
REQ-013 Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-014 FETCH: adr_src=0, alu_src_a=1, alu_src_b=2, alu_control=ADD, result_src=2; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
REQ-015 DECODE: latch op, funct, rd into internal registers; alu_src_a=1, alu_src_b=2, result_src=2; next is MEMADR (op=1), EXECI (op=0, funct[5]=1), EXECR (op=0, funct[5]=0), BRANCH (op=2), or FETCH with a one-cycle illegal pulse (op=3).
REQ-016 All later states decode only the latched fields; input changes after DECODE have no effect.
REQ-017 MEMADR: alu_src_a=0, alu_src_b=1, ADD, imm_src=1; next MEMRD if L=1, else MEMWR.
REQ-018 MEMRD: adr_src=1; hold until mem_ready=1, then MEMWB.
REQ-019 MEMWB: result_src=1, reg_w=cond_ex, pc_write=cond_ex when rd==PC_REG; next FETCH.
REQ-020 MEMWR: adr_src=1, reg_src[1]=1, mem_w=cond_ex for every cycle spent in the state; hold until mem_ready=1, then FETCH.
REQ-021 EXECR: alu_src_b=0; EXECI: alu_src_b=1, imm_src=0; both go to ALUWB.
REQ-022 ALU cmd map in EXECR/EXECI: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 1010 CMP=1, 1000 TST=2, 1011 CMN=0, 0101 ADC=4, 1101 LSL=0 with shift_flag=1; any other cmd gives alu_control=0 and illegal=1 for that cycle.
REQ-023 In EXECR/EXECI: flag_w[1]=S&cond_ex; flag_w[0]=S&cond_ex only for ADD/SUB/CMP/CMN/ADC.
REQ-024 no_write=1 for CMP, TST, CMN.
REQ-025 ALUWB: result_src=0, reg_w=cond_ex&~no_write, pc_write=reg_w&(rd==PC_REG); next FETCH.
REQ-026 BRANCH: alu_src_a=0, alu_src_b=1, imm_src=2, reg_src[0]=1, result_src=2, pc_write=cond_ex; next FETCH.
REQ-027 Any output not listed for a state is 0 in that state.
REQ-028 retired increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH; an illegal return does not count.

Reset
REQ-029 While rst_n=0 at a clock edge: state becomes FETCH, latched fields and retired clear to 0, and every combinational output is forced to 0.
REQ-030 Reset asserted mid-instruction, including an in-progress memory wait, aborts the instruction with no reg_w, mem_w or pc_write afterwards.

Structure
REQ-031 A shared package holds the state encoding, ALU control codes, cmd opcodes and the result_src/alu_src_b enumerations.
REQ-032 Use one sub-module, alu_dec, as the combinational cmd-to-alu_control/flag_w/no_write/shift_flag/illegal decoder; the FSM stays in the top module.

Verification
REQ-033 ADD r1 (op=0, funct=001000), cond_ex=1, mem_ready=1: FETCH,DECODE,EXECR,ALUWB; reg_w=1 only in ALUWB; retired=1.
REQ-034 LDR (op=1, funct[0]=1), mem_ready low 3 cycles in MEMRD: state holds MEMRD 4 cycles; reg_w in MEMWB; 5+3 cycles total.
REQ-035 STR with cond_ex=0: mem_w=0 throughout MEMWR, returns to FETCH, retired increments.
REQ-036 CMP with S=1 (cmd=1010): flag_w=11 in EXECR; reg_w=0 in ALUWB.
REQ-037 MOV-class write to rd=15 via ALUWB: pc_write=1; op=3 gives illegal pulse and retired unchanged.
REQ-038 rst_n low while in MEMWR: next state FETCH, no mem_w afterwards, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU control codes,
// data-processing cmd opcodes and the result/ALU-B source selects.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_ADC = 3'd4;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_LSL = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'd0,
        RES_DATA      = 2'd1,
        RES_ALURESULT = 2'd2
    } result_src_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } alu_src_b_t;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational data-processing decoder: cmd/S/cond_ex to ALU control, flag
// write enables, no_write, shift_flag and illegal-cmd indication.
module alu_dec
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [3:0]            i_cmd,
    input  logic                  i_s_bit,
    input  logic                  i_cond_ex,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic [1:0]            o_flag_w,
    output logic                  o_no_write,
    output logic                  o_shift_flag,
    output logic                  o_illegal
);

    logic w_arith;
    logic w_flag_en;

    always_comb begin
        o_alu_control = '0;
        o_no_write    = 1'b0;
        o_shift_flag  = 1'b0;
        o_illegal     = 1'b0;
        w_arith       = 1'b0;
        case (i_cmd)
            CMD_ADD: begin o_alu_control = ALU_CTRL_W'(ALU_ADD); w_arith = 1'b1; end
            CMD_SUB: begin o_alu_control = ALU_CTRL_W'(ALU_SUB); w_arith = 1'b1; end
            CMD_AND: o_alu_control = ALU_CTRL_W'(ALU_AND);
            CMD_ORR: o_alu_control = ALU_CTRL_W'(ALU_ORR);
            CMD_CMP: begin
                o_alu_control = ALU_CTRL_W'(ALU_SUB);
                w_arith       = 1'b1;
                o_no_write    = 1'b1;
            end
            CMD_TST: begin
                o_alu_control = ALU_CTRL_W'(ALU_AND);
                o_no_write    = 1'b1;
            end
            CMD_CMN: begin
                o_alu_control = ALU_CTRL_W'(ALU_ADD);
                w_arith       = 1'b1;
                o_no_write    = 1'b1;
            end
            CMD_ADC: begin o_alu_control = ALU_CTRL_W'(ALU_ADC); w_arith = 1'b1; end
            CMD_LSL: begin o_alu_control = ALU_CTRL_W'(ALU_ADD); o_shift_flag = 1'b1; end
            default: o_illegal = 1'b1;
        endcase
    end

    // NZ flags follow S for every cmd; CV only for the arithmetic ones
    assign w_flag_en = i_s_bit & i_cond_ex;
    assign o_flag_w  = {w_flag_en, w_flag_en & w_arith};

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/memory/execute/branch sequencing
// plus a retired-instruction counter. Memory states stall on mem_ready.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 4,
    parameter int PC_REG     = 15,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  cond_ex,
    input  logic                  mem_ready,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_w,
    output logic                  mem_w,
    output logic                  adr_src,
    output logic                  alu_src_a,
    output logic                  no_write,
    output logic                  shift_flag,
    output logic                  illegal,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [1:0]            flag_w,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [CNT_W-1:0]      retired,
    output logic [3:0]            state
);

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic [5:0]            r_funct;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [CNT_W-1:0]      r_retired;

    logic [ALU_CTRL_W-1:0] w_dec_alu;
    logic [1:0]            w_dec_flag_w;
    logic                  w_dec_no_write;
    logic                  w_dec_shift;
    logic                  w_dec_illegal;
    logic                  w_rd_is_pc;
    logic                  w_alu_reg_w;
    logic                  w_retire;
    logic                  w_unused_latched;

    alu_dec #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .i_cmd         (r_funct[4:1]),
        .i_s_bit       (r_funct[0]),
        .i_cond_ex     (cond_ex),
        .o_alu_control (w_dec_alu),
        .o_flag_w      (w_dec_flag_w),
        .o_no_write    (w_dec_no_write),
        .o_shift_flag  (w_dec_shift),
        .o_illegal     (w_dec_illegal)
    );

    assign w_rd_is_pc       = (r_rd == REG_ADDR_W'(PC_REG));
    assign w_alu_reg_w      = cond_ex & ~w_dec_no_write;
    assign w_unused_latched = ^{r_op, r_funct[5]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_funct   <= '0;
            r_rd      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op    <= op;
                r_funct <= funct;
                r_rd    <= rd;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        no_write    = 1'b0;
        shift_flag  = 1'b0;
        illegal     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_b   = SRCB_REG;
        imm_src     = 2'd0;
        reg_src     = 2'd0;
        flag_w      = 2'd0;
        alu_control = ALU_CTRL_W'(ALU_ADD);
        // Every decoded output stays at zero while reset is held
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    if (mem_ready) w_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    case (op)
                        OP_MEM:  w_next = S_MEMADR;
                        OP_DP:   w_next = funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   w_next = S_BRANCH;
                        default: begin
                            illegal = 1'b1;
                            w_next  = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_b = SRCB_IMM;
                    imm_src   = 2'd1;
                    w_next    = r_funct[0] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    adr_src = 1'b1;
                    if (mem_ready) w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_w      = cond_ex;
                    pc_write   = cond_ex & w_rd_is_pc;
                    w_next     = S_FETCH;
                end
                S_MEMWR: begin
                    adr_src = 1'b1;
                    reg_src = 2'b10;
                    mem_w   = cond_ex;
                    if (mem_ready) w_next = S_FETCH;
                end
                S_EXECR, S_EXECI: begin
                    alu_src_b   = (r_state == S_EXECI) ? SRCB_IMM : SRCB_REG;
                    alu_control = w_dec_alu;
                    flag_w      = w_dec_flag_w;
                    no_write    = w_dec_no_write;
                    shift_flag  = w_dec_shift;
                    illegal     = w_dec_illegal;
                    w_next      = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_w    = w_alu_reg_w;
                    pc_write = w_alu_reg_w & w_rd_is_pc;
                    w_next   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_b  = SRCB_IMM;
                    imm_src    = 2'd2;
                    reg_src    = 2'b01;
                    result_src = RES_ALURESULT;
                    pc_write   = cond_ex;
                    w_next     = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    // An undefined op returns to FETCH from DECODE and is deliberately not counted
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state == S_MEMWB || r_state == S_MEMWR ||
                       r_state == S_ALUWB || r_state == S_BRANCH);

    assign retired = r_retired;
    assign state   = r_state;

endmodule
